// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : music_pkg
//  Purpose  : Shared definitions for the music ROM arbitration slice:
//             requester ids, the in-flight tag record and the round-robin
//             successor helper.
//  Revision : 1.0 - initial release
// ============================================================================
package music_pkg;

    // Requester ids; 3 is never issued
    localparam int REQ_MUSIC       = 0;
    localparam int REQ_SFX         = 1;
    localparam int REQ_CPU         = 2;
    localparam int N_REQ           = 3;

    localparam int MUSIC_ROM_WIDTH = 17;

    // One stage of the read-tag pipeline: which requester owns the read
    // currently travelling through the ROM.
    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } music_tag_t;

    // Round-robin successor. Wraps by comparing against 2 rather than
    // relying on 2-bit overflow, because id 3 does not exist.
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/music_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : music_rr_pick
//  Purpose  : Combinational 3-way round-robin picker. Scans the eligible
//             vector starting just after the last granted requester.
//  Ports    : eligible[2:0]  in   requesters allowed to issue this cycle
//             last[1:0]      in   id granted most recently
//             grant_valid    out  some requester was picked
//             grant_id[1:0]  out  picked requester (0..2)
//  Revision : 1.0 - initial release
// ============================================================================
module music_rr_pick
    import music_pkg::*;
(
    input  logic [N_REQ-1:0] eligible,
    input  logic [1:0]       last,
    output logic             grant_valid,
    output logic [1:0]       grant_id
);

    logic [1:0] w_first;
    logic [1:0] w_second;
    logic [1:0] w_third;

    // Priority order for this cycle; the third slot is the last grantee,
    // so a lone requester is never locked out.
    assign w_first  = rr_next(last);
    assign w_second = rr_next(w_first);
    assign w_third  = rr_next(w_second);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = w_first;
        if (eligible[w_first]) begin
            grant_valid = 1'b1;
            grant_id    = w_first;
        end else if (eligible[w_second]) begin
            grant_valid = 1'b1;
            grant_id    = w_second;
        end else if (eligible[w_third]) begin
            grant_valid = 1'b1;
            grant_id    = w_third;
        end
    end

endmodule
`default_nettype wire

// File: rtl/music_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : music_rom_arbiter
//  Purpose  : Shares the single synchronous music ROM read port between the
//             music player, the sound-effect player and the CPU loader.
//             Round-robin grant, one address issued per clock, a tag
//             pipeline tracks each read to its one-cycle valid strobe.
//  Ports    : clk, reset_n (synchronous, active-low)
//             req[2:0]            read requests (0 music, 1 sfx, 2 cpu)
//             req_addr0..2        per-requester read address
//             rvalid[2:0]         one-cycle read-data strobe
//             rdata0..2           per-requester read data (held)
//             busy[2:0]           per-requester read in flight
//             rom_addr            registered ROM address
//             rom_data            ROM output data
//  Revision : 1.0 - initial release
// ============================================================================
module music_rom_arbiter
    import music_pkg::*;
#(
    parameter int ROM_WIDTH   = MUSIC_ROM_WIDTH,
    parameter int ROM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           req,
    input  logic [ROM_WIDTH-1:0] req_addr0,
    input  logic [ROM_WIDTH-1:0] req_addr1,
    input  logic [ROM_WIDTH-1:0] req_addr2,
    output logic [2:0]           rvalid,
    output logic [7:0]           rdata0,
    output logic [7:0]           rdata1,
    output logic [7:0]           rdata2,
    output logic [2:0]           busy,
    output logic [ROM_WIDTH-1:0] rom_addr,
    input  logic [7:0]           rom_data
);

    localparam logic [1:0] c_ID_MUSIC = 2'(REQ_MUSIC);
    localparam logic [1:0] c_ID_SFX   = 2'(REQ_SFX);
    localparam logic [1:0] c_ID_CPU   = 2'(REQ_CPU);
    // Pointer starts at cpu so music wins the first contention
    localparam logic [1:0] c_RR_RESET = c_ID_CPU;

    logic [2:0]           w_eligible;
    logic                 w_grant_valid;
    logic [1:0]           w_grant_id;
    logic [2:0]           w_grant_oh;
    logic [ROM_WIDTH-1:0] w_grant_addr;
    logic [2:0]           w_capture_oh;
    music_tag_t           w_final;

    music_tag_t           r_tag [ROM_LATENCY+1];
    logic [1:0]           r_last;
    logic [2:0]           r_busy;
    logic [2:0]           r_rvalid;
    logic [7:0]           r_rdata0;
    logic [7:0]           r_rdata1;
    logic [7:0]           r_rdata2;
    logic [ROM_WIDTH-1:0] r_rom_addr;

    // A requester with a read in flight cannot issue another
    assign w_eligible = req & ~r_busy;

    music_rr_pick u_pick (
        .eligible    (w_eligible),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_comb begin
        w_grant_oh   = 3'b000;
        w_grant_addr = req_addr0;
        if (w_grant_valid) begin
            case (w_grant_id)
                c_ID_MUSIC: begin w_grant_oh = 3'b001; w_grant_addr = req_addr0; end
                c_ID_SFX:   begin w_grant_oh = 3'b010; w_grant_addr = req_addr1; end
                c_ID_CPU:   begin w_grant_oh = 3'b100; w_grant_addr = req_addr2; end
                default:    ;
            endcase
        end
    end

    // The last tag stage lines up with the cycle rom_data answers the
    // address issued ROM_LATENCY+1 edges earlier.
    assign w_final = r_tag[ROM_LATENCY];

    always_comb begin
        w_capture_oh = 3'b000;
        if (w_final.valid) begin
            case (w_final.id)
                c_ID_MUSIC: w_capture_oh = 3'b001;
                c_ID_SFX:   w_capture_oh = 3'b010;
                c_ID_CPU:   w_capture_oh = 3'b100;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k <= ROM_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_grant_valid;
            r_tag[0].id    <= w_grant_id;
            for (int k = 1; k <= ROM_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last     <= c_RR_RESET;
            r_busy     <= 3'b000;
            r_rvalid   <= 3'b000;
            r_rdata0   <= 8'h00;
            r_rdata1   <= 8'h00;
            r_rdata2   <= 8'h00;
            r_rom_addr <= '0;
        end else begin
            r_rvalid <= w_capture_oh;
            // Grant and capture never hit the same bit: a captured
            // requester is still busy this cycle and so not eligible.
            r_busy   <= (r_busy & ~w_capture_oh) | w_grant_oh;
            if (w_grant_valid) begin
                r_rom_addr <= w_grant_addr;
                r_last     <= w_grant_id;
            end
            if (w_capture_oh[0]) r_rdata0 <= rom_data;
            if (w_capture_oh[1]) r_rdata1 <= rom_data;
            if (w_capture_oh[2]) r_rdata2 <= rom_data;
        end
    end

    assign rvalid   = r_rvalid;
    assign busy     = r_busy;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign rdata2   = r_rdata2;
    assign rom_addr = r_rom_addr;

endmodule
`default_nettype wire
